// File: rtl/demux1to4_32bit_reg.sv
// demux1to4_32bit_reg
// Routes one write stream into four independent single-entry lane buffers.
// Each lane holds one word plus a valid flag. It can be refilled in the same
// cycle it is drained, so a lane can take one word every cycle with no gap.
// Every accepted word bumps an 8-bit wrapping counter for its lane.

module demux1to4_32bit_reg #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] In,
    input  logic [1:0]       Sel,
    input  logic             InValid,
    output logic             InReady,
    output logic [WIDTH-1:0] Out0,
    output logic [WIDTH-1:0] Out1,
    output logic [WIDTH-1:0] Out2,
    output logic [WIDTH-1:0] Out3,
    output logic [3:0]       OutValid,
    input  logic [3:0]       OutReady,
    output logic [31:0]      LaneCount
);

    logic [WIDTH-1:0] laneData [4];
    logic [3:0]       laneValid;
    logic [7:0]       laneCnt  [4];
    logic             accept;
    logic [3:0]       acceptLane;
    logic [3:0]       drainLane;

    // The selected lane can take a word when it is empty or is being emptied this cycle; never during reset
    always_comb begin
        InReady = (!laneValid[Sel] || OutReady[Sel]) && !Reset;
    end

    // Decode the accept into a one-hot lane strobe and find which full lanes are being consumed
    always_comb begin
        accept            = InValid && InReady;
        acceptLane        = 4'b0000;
        if (accept) begin
            acceptLane[Sel] = 1'b1;
        end
        drainLane         = laneValid & OutReady;
    end

    // Lane storage: a refill takes priority over a drain so the lane stays valid; a plain drain keeps the data
    always_ff @(posedge Clk) begin
        if (Reset) begin
            laneValid <= 4'b0000;
            for (int k = 0; k < 4; k++) begin
                laneData[k] <= '0;
                laneCnt[k]  <= 8'd0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (acceptLane[k]) begin
                    laneData[k]  <= In;
                    laneValid[k] <= 1'b1;
                    laneCnt[k]   <= laneCnt[k] + 8'd1;
                end else if (drainLane[k]) begin
                    laneValid[k] <= 1'b0;
                end
            end
        end
    end

    // Drive the outputs straight from the lane registers
    always_comb begin
        Out0      = laneData[0];
        Out1      = laneData[1];
        Out2      = laneData[2];
        Out3      = laneData[3];
        OutValid  = laneValid;
        LaneCount = {laneCnt[3], laneCnt[2], laneCnt[1], laneCnt[0]};
    end

endmodule

// File: tb/tb_demux1to4_32bit_reg.sv
// tb_demux1to4_32bit_reg
// Self-checking bench for the 1-to-4 lane demux. It tracks every accepted word in
// a queue for its lane and pops it when the consumer drains that lane. It also
// keeps the lane flags and counters, and it steps through a table of
// hand-derived vectors and several directed corner-case sequences.

module tb_demux1to4_32bit_reg;

    typedef struct {
        logic        rst;
        logic [31:0] din;
        logic [1:0]  sel;
        logic        inValid;
        logic [3:0]  outReady;
        logic        expReady;
        logic [3:0]  expValid;
        logic [31:0] expCount;
    } vec_t;

    logic        Clk;
    logic        Reset;
    logic [31:0] In;
    logic [1:0]  Sel;
    logic        InValid;
    logic        InReady;
    logic [31:0] Out0;
    logic [31:0] Out1;
    logic [31:0] Out2;
    logic [31:0] Out3;
    logic [3:0]  OutValid;
    logic [3:0]  OutReady;
    logic [31:0] LaneCount;

    int checks;
    int errors;

    logic [31:0] expQ [4][$];
    logic [3:0]  mValid;
    logic [31:0] mData [4];
    logic [7:0]  mCnt  [4];

    vec_t vecs [7];

    demux1to4_32bit_reg #(.WIDTH(32)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .In        (In),
        .Sel       (Sel),
        .InValid   (InValid),
        .InReady   (InReady),
        .Out0      (Out0),
        .Out1      (Out1),
        .Out2      (Out2),
        .Out3      (Out3),
        .OutValid  (OutValid),
        .OutReady  (OutReady),
        .LaneCount (LaneCount)
    );

    // Free-running clock
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endfunction

    function automatic logic [31:0] laneOut(input int k);
        case (k)
            0:       return Out0;
            1:       return Out1;
            2:       return Out2;
            default: return Out3;
        endcase
    endfunction

    task automatic checkOutput();
        check("outValid", {28'd0, OutValid}, {28'd0, mValid});
        check("laneCount", LaneCount, {mCnt[3], mCnt[2], mCnt[1], mCnt[0]});
        for (int k = 0; k < 4; k++) begin
            check($sformatf("out%0d", k), laneOut(k), mData[k]);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic [31:0] din, input logic [1:0] sel,
                                 input logic iv, input logic [3:0] ordy, output logic readySeen);
        logic        expReady;
        logic        acc;
        logic [31:0] popped;
        @(negedge Clk);
        Reset    = rst;
        In       = din;
        Sel      = sel;
        InValid  = iv;
        OutReady = ordy;
        #1;
        expReady  = !rst && (!mValid[sel] || ordy[sel]);
        readySeen = InReady;
        check("inReady", {31'd0, InReady}, {31'd0, expReady});
        acc = iv && expReady;
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                expQ[k].delete();
                mData[k] = 32'd0;
                mCnt[k]  = 8'd0;
            end
            mValid = 4'b0000;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (mValid[k] && ordy[k] && expQ[k].size() != 0) begin
                    popped = expQ[k].pop_front();
                    check($sformatf("drain%0d", k), laneOut(k), popped);
                    mValid[k] = 1'b0;
                end
            end
            if (acc) begin
                expQ[sel].push_back(din);
                mValid[sel] = 1'b1;
                mData[sel]  = din;
                mCnt[sel]   = mCnt[sel] + 8'd1;
            end
        end
        @(posedge Clk);
        #1;
        checkOutput();
    endtask

    // Main test sequence
    initial begin
        logic rdy;
        checks   = 0;
        errors   = 0;
        Reset    = 1'b1;
        In       = 32'd0;
        Sel      = 2'd0;
        InValid  = 1'b0;
        OutReady = 4'b0000;
        mValid   = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            mData[k] = 32'd0;
            mCnt[k]  = 8'd0;
        end

        vecs[0] = '{1'b0, 32'hDEADBEEF, 2'd2, 1'b1, 4'b0000, 1'b1, 4'b0100, 32'h00010000};
        vecs[1] = '{1'b0, 32'h11111111, 2'd0, 1'b1, 4'b0000, 1'b1, 4'b0101, 32'h00010001};
        vecs[2] = '{1'b0, 32'h22222222, 2'd0, 1'b1, 4'b0001, 1'b1, 4'b0101, 32'h00010002};
        vecs[3] = '{1'b0, 32'h33333333, 2'd2, 1'b1, 4'b0000, 1'b0, 4'b0101, 32'h00010002};
        vecs[4] = '{1'b0, 32'h44444444, 2'd3, 1'b1, 4'b0100, 1'b1, 4'b1001, 32'h01010002};
        vecs[5] = '{1'b0, 32'h55555555, 2'd1, 1'b0, 4'b1001, 1'b1, 4'b0000, 32'h01010002};
        vecs[6] = '{1'b0, 32'h66666666, 2'd1, 1'b0, 4'b0010, 1'b1, 4'b0000, 32'h01010002};

        applyStimulus(1'b1, 32'h0, 2'd0, 1'b1, 4'b0000, rdy);
        applyStimulus(1'b1, 32'h0, 2'd0, 1'b0, 4'b0000, rdy);
        check("resetReady", {31'd0, rdy}, 32'd0);

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].din, vecs[i].sel, vecs[i].inValid, vecs[i].outReady, rdy);
            check($sformatf("vec%0dReady", i), {31'd0, rdy}, {31'd0, vecs[i].expReady});
            check($sformatf("vec%0dValid", i), {28'd0, OutValid}, {28'd0, vecs[i].expValid});
            check($sformatf("vec%0dCount", i), LaneCount, vecs[i].expCount);
        end

        applyStimulus(1'b0, 32'hAAAA0001, 2'd1, 1'b1, 4'b0000, rdy);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 32'hBBBB0000 + i, 2'd1, 1'b1, 4'b0000, rdy);
            check("bpReady", {31'd0, rdy}, 32'd0);
            check("bpHold", Out1, 32'hAAAA0001);
        end
        applyStimulus(1'b0, 32'hCCCC0003, 2'd3, 1'b1, 4'b0000, rdy);
        check("selSwitchReady", {31'd0, rdy}, 32'd1);
        check("selSwitchOut3", Out3, 32'hCCCC0003);
        check("selSwitchOut1", Out1, 32'hAAAA0001);

        applyStimulus(1'b0, 32'h0, 2'd0, 1'b0, 4'b1000, rdy);
        check("drainOnlyValid3", {31'd0, OutValid[3]}, 32'd0);
        check("drainOnlyHold3", Out3, 32'hCCCC0003);
        applyStimulus(1'b0, 32'h0, 2'd0, 1'b0, 4'b0010, rdy);

        applyStimulus(1'b0, 32'h11111111, 2'd0, 1'b1, 4'b0000, rdy);
        applyStimulus(1'b0, 32'h22222222, 2'd0, 1'b1, 4'b0001, rdy);
        check("passThroughReady", {31'd0, rdy}, 32'd1);
        check("passThroughValid0", {31'd0, OutValid[0]}, 32'd1);
        check("passThroughOut0", Out0, 32'h22222222);

        applyStimulus(1'b1, 32'h0, 2'd0, 1'b0, 4'b0000, rdy);
        for (int i = 0; i < 256; i++) begin
            applyStimulus(1'b0, i, 2'd0, 1'b1, 4'b0001, rdy);
            check("wrapReady", {31'd0, rdy}, 32'd1);
            if (i == 254) begin
                check("wrapCountFF", {24'd0, LaneCount[7:0]}, 32'h000000FF);
            end
        end
        check("wrapCount00", {24'd0, LaneCount[7:0]}, 32'h00000000);
        check("wrapOut0", Out0, 32'd255);

        applyStimulus(1'b0, 32'h0000AAAA, 2'd1, 1'b1, 4'b0000, rdy);
        applyStimulus(1'b0, 32'h0000BBBB, 2'd2, 1'b1, 4'b0000, rdy);
        applyStimulus(1'b0, 32'h0000CCCC, 2'd3, 1'b1, 4'b0000, rdy);
        check("allFull", {28'd0, OutValid}, 32'h0000000F);
        applyStimulus(1'b1, 32'hEEEEEEEE, 2'd0, 1'b1, 4'b0000, rdy);
        check("midResetReady", {31'd0, rdy}, 32'd0);
        check("midResetValid", {28'd0, OutValid}, 32'd0);
        check("midResetCount", LaneCount, 32'd0);
        check("midResetOut0", Out0, 32'd0);
        check("midResetOut3", Out3, 32'd0);
        applyStimulus(1'b0, 32'h12345678, 2'd2, 1'b1, 4'b0000, rdy);
        check("postResetReady", {31'd0, rdy}, 32'd1);
        check("postResetOut2", Out2, 32'h12345678);
        check("postResetCount", LaneCount, 32'h00010000);

        for (int i = 0; i < 300; i++) begin
            applyStimulus(($urandom_range(0, 49) == 0), $urandom, 2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), rdy);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux1to4_32bit_reg.md
DEMUX1TO4_32BIT_REG -- requirements
Module: demux1to4_32bit_reg

Interface
REQ-001 Parameter: WIDTH, 32, data width of input and each output lane.
REQ-002 Clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 In  input  WIDTH  write data.
REQ-005 Sel  input  2  destination lane: 0..3 selects Out0..Out3.
REQ-006 InValid  input  1  In/Sel valid this cycle.
REQ-007 InReady  output  1  block accepts In this cycle.
REQ-008 Out0, Out1, Out2, Out3  output  WIDTH each  lane data registers.
REQ-009 OutValid  output  4  bit k = lane k holds unconsumed data.
REQ-010 OutReady  input  4  bit k = consumer of lane k takes data this cycle.
REQ-011 LaneCount  output  32  bits [8k+7:8k] = accepted-word count of lane k.

Function
REQ-012 Each lane SHALL be a one-entry buffer: data register Outk plus flag OutValid[k].
REQ-013 InReady SHALL equal (!OutValid[Sel] | OutReady[Sel]) & !Reset, combinationally.
REQ-014 Accept SHALL occur in a cycle with InValid=1 and InReady=1; In and Sel are don't-care otherwise.
REQ-015 On accept to lane s: next edge Outs<=In, OutValid[s]<=1; latency exactly 1 cycle.
REQ-016 Drain of lane k SHALL occur in a cycle with OutValid[k]=1 and OutReady[k]=1.
REQ-017 Drain without a simultaneous accept to the same lane: OutValid[k]<=0 next edge; Outk holds its last value.
REQ-018 Simultaneous drain and accept on the same lane: OutValid stays 1, Outk<=In (full throughput, no bubble).
REQ-019 OutReady[k] while OutValid[k]=0: no effect.
REQ-020 While OutValid[k]=1 and OutReady[k]=0, Outk SHALL remain stable; lanes other than Sel are never written.
REQ-021 Lanes drain independently; up to four drains plus one accept per cycle.
REQ-022 Accept to lane s SHALL increment count s by 1, modulo 256 (255 -> 0); counts never decrement.
REQ-023 Sel changing while InValid=1 and InReady=0 is legal; InReady re-evaluates against the new Sel; no data is lost or duplicated.
REQ-024 No word SHALL be written to a lane whose OutValid=1 unless that lane drains in the same cycle.

Reset
REQ-025 Reset=1 at an edge: Out0..Out3 <= 0, OutValid <= 4'b0000, LaneCount <= 0.
REQ-026 While Reset=1, InReady=0 and no accept occurs, regardless of InValid.
REQ-027 Reset mid-operation discards any buffered, undrained data; counts restart at 0.
REQ-028 First accept is possible in the first cycle after Reset deasserts.

Verification
REQ-029 Reset, then In=0xDEADBEEF, Sel=2, InValid=1 one cycle -> next cycle Out2=0xDEADBEEF, OutValid=4'b0100, LaneCount=0x00010000, others 0.
REQ-030 Lane 1 full, OutReady[1]=0, Sel=1, InValid=1 -> InReady=0, Out1 unchanged for 3 cycles; switch Sel=3 -> InReady=1, Out3 loaded, Out1 untouched.
REQ-031 Lane 0 full (0x11111111), OutReady[0]=1 and accept In=0x22222222 Sel=0 same cycle -> OutValid[0] stays 1, Out0=0x22222222, count0 +1.
REQ-032 Lane 3 full, OutReady[3]=1, InValid=0 -> next cycle OutValid[3]=0, Out3 holds prior value.
REQ-033 256 accepts to lane 0 with OutReady[0]=1 -> LaneCount[7:0] returns to 0x00 after wrap, one word per cycle, no bubbles.
REQ-034 All four lanes full, assert Reset one cycle with InValid=1 -> OutValid=0, all Outk=0, counts 0, InReady=0 during reset, 1 after.
